demux2_64bit_stream: RTL and testbench
======================================

DEMUX2_64BIT_STREAM -- requirements
Module: demux2_64bit_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of one data word.
REQ-002 SHALL have parameter DEPTH, default 2, word entries buffered per output channel.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_data  input  DATA_W  word to route.
REQ-007 in_sel  input  1  destination channel: 0 -> channel 0, 1 -> channel 1.
REQ-008 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-009 in_ready  output  1  module accepts a word this cycle.
REQ-010 out_data  output  2*DATA_W  packed heads: channel 1 in [2*DATA_W-1:DATA_W], channel 0 in [DATA_W-1:0].
REQ-011 out_valid  output  2  bit k: channel k head valid.
REQ-012 out_ready  input  2  bit k: consumer k takes head this cycle.
REQ-013 occ0, occ1  output  2 each  current entry count of channel 0 / channel 1 buffer.
REQ-014 acc0, acc1  output  8 each  words accepted per channel, wrapping modulo 256.

Function
REQ-015 Input transfer SHALL occur when in_valid && in_ready on a rising clk edge; output transfer k when out_valid[k] && out_ready[k].
REQ-016 in_ready SHALL equal (occupancy of channel in_sel) < DEPTH, combinational from in_sel and registered occupancy only; no dependence on out_ready.
REQ-017 Accepted word SHALL be written to channel in_sel FIFO only; the other channel SHALL be unaffected.
REQ-018 Each channel SHALL be FIFO-ordered; word bits SHALL pass unmodified (bit i in -> bit i out, no reordering).
REQ-019 Latency SHALL be exactly 1 cycle: word accepted at edge N appears at channel head with out_valid[k]=1 after edge N when that channel was empty.
REQ-020 out_data channel field SHALL hold the head entry when out_valid[k]=1; value when out_valid[k]=0 SHALL be the last held entry (or 0 after reset).
REQ-021 Per-channel occupancy state SHALL be EMPTY, PARTIAL (0<occ<DEPTH) or FULL; push-only increments, pop-only decrements, push+pop same cycle on same channel holds occupancy.
REQ-022 Push+pop same cycle on a FULL channel SHALL NOT occur (in_ready=0); push+pop on EMPTY channel SHALL NOT occur (out_valid=0).
REQ-023 Simultaneous push to channel j and pop from channel k (j != k) SHALL both complete in that cycle.
REQ-024 Head-of-line blocking: a word for a FULL channel SHALL stall input even if the other channel has space.
REQ-025 acc0/acc1 SHALL increment by 1 on each accepted word for that channel, wrapping 255 -> 0.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 While rst_n=0 at a clk edge: all occupancies 0, pointers 0, out_valid=2'b00, out_data=0, acc0=acc1=0; in_ready then equals 1.
REQ-028 Reset mid-operation SHALL discard all buffered words; no output transfer SHALL be reported in the reset cycle.

Structure
REQ-029 DATA_W default, DEPTH default, occupancy-state encoding (EMPTY/PARTIAL/FULL) and counter width 8 SHALL live in a shared package.
REQ-030 One sub-module, chan_fifo (DATA_W x DEPTH synchronous FIFO with push/pop/occ/head), SHALL be instantiated twice.

Verification
REQ-031 Reset then in_data=64'h0123456789ABCDEF, in_sel=1, one push -> next cycle out_valid=2'b10, out_data[127:64]=64'h0123456789ABCDEF, occ1=1, acc1=1.
REQ-032 out_ready=2'b00, three pushes to channel 0 (A,B,C) -> A,B accepted, in_ready=0 on C, occ0=2; raise out_ready[0] -> A then B then C emitted in order.
REQ-033 Channel 1 FULL, in_sel=1 with valid -> in_ready=0 held; channel 0 traffic stalled behind it; pop one from channel 1 -> stalled word accepted next edge.
REQ-034 Push to channel 0 and pop from channel 1 same cycle, occ0=1, occ1=1 -> after edge occ0=2, occ1=0.
REQ-035 256 words to channel 0 -> acc0 wraps to 0, acc1 stays 0.
REQ-036 rst_n=0 with occ0=2, occ1=1 -> next cycle out_valid=2'b00, occ0=occ1=0, acc0=acc1=0, in_ready=1.

Source files
------------

// File: rtl/demux2_64bit_stream_pkg.sv
// Shared widths, depths and occupancy-state encoding for the two-way 64-bit stream demux.
// The channel FIFO and the top both import this package.
package demux2_64bit_stream_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 2;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    typedef struct packed {
        occ_state_e ch1;
        occ_state_e ch0;
    } dbg_state_t;

    function automatic occ_state_e occ_to_state(input int occ, input int depth);
        if (occ == 0) return OCC_EMPTY;
        if (occ >= depth) return OCC_FULL;
        return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/demux2_64bit_stream_chan_fifo.sv
// chan_fifo: DATA_W x DEPTH synchronous FIFO with a registered head word, so the head
// field keeps showing the last entry after the channel drains.
module chan_fifo
    import demux2_64bit_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full,
    output logic [OCC_W-1:0]  occ,
    output occ_state_e        state
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem   [DEPTH];
    logic [DATA_W-1:0] mem_n [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_n, rd_n;
    logic [OCC_W-1:0]  occ_n;
    logic [DATA_W-1:0] head_n;
    logic              push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Guard against illegal requests so occupancy can never over- or underflow.
    assign push_ok = push && (state != OCC_FULL);
    assign pop_ok  = pop && valid;
    assign full    = (state == OCC_FULL);

    always_comb begin
        mem_n = mem;
        if (push_ok) mem_n[wr_ptr] = din;
        wr_n  = push_ok ? ptr_inc(wr_ptr) : wr_ptr;
        rd_n  = pop_ok ? ptr_inc(rd_ptr) : rd_ptr;
        occ_n = occ;
        if (push_ok && !pop_ok) occ_n = occ + OCC_W'(1);
        else if (!push_ok && pop_ok) occ_n = occ - OCC_W'(1);
        // Look ahead through this cycle's write so a push into an empty slot lands at the head.
        head_n = (occ_n != '0) ? mem_n[rd_n] : head;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            state  <= OCC_EMPTY;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_n;
            rd_ptr <= rd_n;
            occ    <= occ_n;
            state  <= occ_to_state(int'(occ_n), DEPTH);
            valid  <= (occ_n != '0);
            head   <= head_n;
        end
    end

endmodule

// File: rtl/demux2_64bit_stream.sv
// Routes one input word stream to two buffered output channels chosen by in_sel.
// Input stalls whenever the selected channel is full, even if the other has room.
module demux2_64bit_stream
    import demux2_64bit_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2*DATA_W-1:0] out_data,
    output logic [1:0]          out_valid,
    input  logic [1:0]          out_ready,
    output logic [1:0]          occ0,
    output logic [1:0]          occ1,
    output logic [CNT_W-1:0]    acc0,
    output logic [CNT_W-1:0]    acc1,
    output dbg_state_t          dbg_state
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              full0, full1;
    logic              push0, push1, pop0, pop1;
    logic [OCC_W-1:0]  occ0_w, occ1_w;
    logic [DATA_W-1:0] head0, head1;
    occ_state_e        st0, st1;

    // Valid/ready: a word moves on a rising edge when valid and ready are both high;
    // in_ready depends only on in_sel and registered occupancy, never on out_ready.
    assign in_ready = in_sel ? !full1 : !full0;
    assign push0    = in_valid && in_ready && !in_sel;
    assign push1    = in_valid && in_ready && in_sel;
    assign pop0     = out_valid[0] && out_ready[0];
    assign pop1     = out_valid[1] && out_ready[1];

    chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OCC_W(OCC_W)) u_chan0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .din   (in_data),
        .pop   (pop0),
        .head  (head0),
        .valid (out_valid[0]),
        .full  (full0),
        .occ   (occ0_w),
        .state (st0)
    );

    chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OCC_W(OCC_W)) u_chan1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .din   (in_data),
        .pop   (pop1),
        .head  (head1),
        .valid (out_valid[1]),
        .full  (full1),
        .occ   (occ1_w),
        .state (st1)
    );

    assign out_data      = {head1, head0};
    assign occ0          = 2'(occ0_w);
    assign occ1          = 2'(occ1_w);
    assign dbg_state.ch0 = st0;
    assign dbg_state.ch1 = st1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc0 <= '0;
            acc1 <= '0;
        end else begin
            if (push0) acc0 <= acc0 + CNT_W'(1);
            if (push1) acc1 <= acc1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux2_64bit_stream.sv
// Bench for demux2_64bit_stream: directed scenarios plus random traffic, checked against
// a queue-per-channel reference model by a negedge monitor.
module tb_demux2_64bit_stream;
    import demux2_64bit_stream_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   in_data;
    logic            in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] out_data;
    logic [1:0]      out_valid;
    logic [1:0]      out_ready;
    logic [1:0]      occ0, occ1;
    logic [7:0]      acc0, acc1;
    dbg_state_t      dbg_state;

    demux2_64bit_stream #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occ0      (occ0),
        .occ1      (occ1),
        .acc0      (acc0),
        .acc1      (acc1),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] last_head [2];
    int            macc [2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the model, then predict the transfers of the coming edge.
    int            sz [2];
    logic [DW-1:0] hd [2];
    logic [DW-1:0] fld;
    logic [1:0]    st_bits;
    always @(negedge clk) begin
        if (mon_en) begin
            sz[0] = exp_q0.size();
            sz[1] = exp_q1.size();
            hd[0] = (sz[0] > 0) ? exp_q0[0] : '0;
            hd[1] = (sz[1] > 0) ? exp_q1[0] : '0;
            check("in_ready", in_ready, sz[in_sel] < DEPTH);
            check("occ0", occ0, sz[0]);
            check("occ1", occ1, sz[1]);
            check("acc0", acc0, macc[0] % 256);
            check("acc1", acc1, macc[1] % 256);
            for (int k = 0; k < 2; k++) begin
                fld     = (k == 1) ? out_data[2*DW-1:DW] : out_data[DW-1:0];
                st_bits = (k == 1) ? dbg_state.ch1 : dbg_state.ch0;
                check($sformatf("out_valid%0d", k), out_valid[k], sz[k] > 0);
                check($sformatf("state%0d", k), st_bits,
                      (sz[k] == 0) ? 2'd0 : (sz[k] >= DEPTH) ? 2'd2 : 2'd1);
                if (sz[k] > 0) begin
                    check($sformatf("head%0d", k), fld, hd[k]);
                    last_head[k] = hd[k];
                end else begin
                    check($sformatf("held%0d", k), fld, last_head[k]);
                end
            end
            if (!rst_n) begin
                exp_q0.delete();
                exp_q1.delete();
                last_head[0] = '0;
                last_head[1] = '0;
                macc[0] = 0;
                macc[1] = 0;
            end else begin
                if (sz[0] > 0 && out_ready[0]) void'(exp_q0.pop_front());
                if (sz[1] > 0 && out_ready[1]) void'(exp_q1.pop_front());
                if (in_valid && sz[in_sel] < DEPTH) begin
                    if (in_sel) exp_q1.push_back(in_data);
                    else exp_q0.push_back(in_data);
                    macc[in_sel]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 2'b00;
        drive(1'b0, 1'b0, '0);
        last_head[0] = '0;
        last_head[1] = '0;
        macc[0] = 0;
        macc[1] = 0;
        step();
        step();
        mon_en = 1'b1;
        step();
        rst_n = 1'b1;

        // Single push to channel 1 appears one cycle later.
        drive(1'b1, 1'b1, 64'h0123456789ABCDEF);
        step();
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        check("d031_valid", out_valid, 2'b10);
        check("d031_data", out_data[127:64], 64'h0123456789ABCDEF);
        check("d031_occ1", occ1, 2'd1);
        check("d031_acc1", acc1, 8'd1);
        step();

        // Fill channel 0 with A,B; C stalls until the consumer drains.
        drive(1'b1, 1'b0, 64'hAAAA_0000_0000_000A);
        step();
        in_data = 64'hBBBB_0000_0000_000B;
        step();
        in_data = 64'hCCCC_0000_0000_000C;
        step();
        @(negedge clk);
        check("d032_ready", in_ready, 1'b0);
        check("d032_occ0", occ0, 2'd2);
        check("d032_head", out_data[63:0], 64'hAAAA_0000_0000_000A);
        step();
        out_ready = 2'b01;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        out_ready = 2'b00;

        // Channel 1 full: input held off until one word leaves channel 1.
        drive(1'b1, 1'b1, 64'h1111_2222_3333_4444);
        step();
        in_data = 64'h5555_6666_7777_8888;
        step();
        step();
        @(negedge clk);
        check("d033_ready", in_ready, 1'b0);
        check("d033_occ1", occ1, 2'd2);
        step();
        out_ready = 2'b10;
        step();
        out_ready = 2'b00;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("d033_occ1_after", occ1, 2'd2);
        step();

        // Push channel 0 while popping channel 1 in the same cycles.
        out_ready = 2'b10;
        drive(1'b1, 1'b0, 64'hD0D0_D0D0_D0D0_D0D0);
        step();
        in_data = 64'hE0E0_E0E0_E0E0_E0E0;
        @(negedge clk);
        check("d034_occ0_pre", occ0, 2'd1);
        check("d034_occ1_pre", occ1, 2'd1);
        step();
        drive(1'b0, 1'b0, '0);
        out_ready = 2'b00;
        @(negedge clk);
        check("d034_occ0", occ0, 2'd2);
        check("d034_occ1", occ1, 2'd0);
        step();

        // Reset with both channels occupied.
        drive(1'b1, 1'b1, 64'hF00D_F00D_F00D_F00D);
        step();
        drive(1'b0, 1'b0, '0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("d036_valid", out_valid, 2'b00);
        check("d036_occ0", occ0, 2'd0);
        check("d036_occ1", occ1, 2'd0);
        check("d036_acc", {acc1, acc0}, 16'h0000);
        check("d036_ready", in_ready, 1'b1);
        step();

        // 256 words through channel 0: its counter wraps back to zero.
        out_ready = 2'b01;
        in_valid  = 1'b1;
        in_sel    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            in_data = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("d035_acc0", acc0, 8'd0);
        check("d035_acc1", acc1, 8'd0);
        step();
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom};
            out_ready = 2'($urandom_range(0, 3));
            step();
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 2'b11;
        repeat (4) step();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
